// File: rtl/eth_tx_arbiter_if.sv
// Frame-source / serializer handshake bundle for the RMII transmit arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface eth_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_data;
  logic [N_REQ-1:0]      req_last;
  logic [N_REQ-1:0]      req_ready;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_last;
  logic                  tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_last
  );
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Whole-frame arbiter for the shared RMII TX path, with an enforced inter-frame gap.
// Define ETH_TX_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module eth_tx_arbiter #(
  parameter int N_REQ      = 2,
  parameter int IFG_CYCLES = 48
) (
  input  logic               eth_clk,
  input  logic               sys_rst_n,
  eth_tx_arbiter_if.slave    bus,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [15:0]        frames_sent
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, PASS, IFG} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] gnt_idx, win_idx;
  logic             win_vld;
  logic [7:0]       ifg_cnt;
  logic             last_hs;
`ifndef ETH_TX_ARB_PRIO_EN
  logic [IDX_W-1:0] rr_last;
`endif

  // Winner search; the last assignment in each loop is the one that wins.
  always_comb begin
    win_idx = '0;
    win_vld = |bus.req_valid;
`ifdef ETH_TX_ARB_PRIO_EN
    for (int i = N_REQ-1; i >= 0; i--)
      if (bus.req_valid[i]) win_idx = IDX_W'(i);
`else
    for (int k = N_REQ; k >= 1; k--) begin
      int s;
      s = int'(rr_last) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (bus.req_valid[IDX_W'(s)]) win_idx = IDX_W'(s);
    end
`endif
  end

  assign last_hs = (state == PASS) && bus.req_valid[gnt_idx] &&
                   bus.req_last[gnt_idx] && bus.tx_ready;

  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = PASS;
      PASS:    if (last_hs) state_nxt = IFG;
      IFG:     if (ifg_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      grant       <= '0;
      gnt_idx     <= '0;
      ifg_cnt     <= '0;
      frames_sent <= '0;
`ifndef ETH_TX_ARB_PRIO_EN
      rr_last     <= IDX_W'(N_REQ-1);
`endif
    end else begin
      if (state == IDLE && win_vld) begin
        grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        gnt_idx <= win_idx;
`ifndef ETH_TX_ARB_PRIO_EN
        rr_last <= win_idx;
`endif
      end
      if (last_hs) begin
        grant       <= '0;
        ifg_cnt     <= 8'(IFG_CYCLES-1);
        frames_sent <= frames_sent + 16'd1;
      end else if (state == IFG && ifg_cnt != '0) begin
        ifg_cnt <= ifg_cnt - 8'd1;
      end
    end
  end

  // Zero-latency passthrough from the owner; everything is quiet outside PASS.
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.tx_last   = 1'b0;
    bus.req_ready = '0;
    busy          = (state != IDLE);
    if (state == PASS) begin
      bus.tx_valid           = bus.req_valid[gnt_idx];
      bus.tx_data            = bus.req_data[gnt_idx];
      bus.tx_last            = bus.req_last[gnt_idx];
      bus.req_ready[gnt_idx] = bus.tx_ready;
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: frame-level reference model (arbitration order, gap timing,
// byte scoreboard, frame count) driven by directed scenarios and a randomized soak.
module tb_eth_tx_arbiter;
  localparam int N   = 3;
  localparam int IFG = 48;

  logic          eth_clk = 1'b0;
  logic          sys_rst_n;
  logic [N-1:0]  grant;
  logic          busy;
  logic [15:0]   frames_sent;

  eth_tx_arbiter_if #(.N_REQ(N)) bus ();

  eth_tx_arbiter #(.N_REQ(N), .IFG_CYCLES(IFG)) dut (
    .eth_clk     (eth_clk),
    .sys_rst_n   (sys_rst_n),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #10 eth_clk = ~eth_clk;

  int checks = 0, failures = 0;

  logic [8:0] drv_q [N][$];  // source-side bytes still to offer, {last,data}
  logic [8:0] sb_q  [N][$];  // bytes expected on tx, per source
  int         hold_off [N];
  int         drop_pct, rdy_mode, cyc;
  bit [N-1:0] hs_in;

  int         m_owner, m_free, m_ptr;
  logic [15:0] m_frames;
  int         grant_log[$], gstart_log[$], end_log[$], gap_log[$];
  logic [8:0] out_log[$];
  int         busy_cnt, bubble_cnt, rr1_hi, ifg_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input bit [N-1:0] v, input int ptr);
`ifdef ETH_TX_ARB_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) return 1'b1;
    return (m_owner >= 0) || (cyc < m_free);
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_free   = 0;
    m_ptr    = N - 1;
    m_frames = '0;
    hs_in    = '0;
    ifg_run  = 0;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      sb_q[i].delete();
      hold_off[i] = 0;
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); gstart_log.delete(); end_log.delete();
    gap_log.delete();   out_log.delete();
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit last);
    drv_q[r].push_back({last, d});
    sb_q[r].push_back({last, d});
  endtask

  task automatic send(input int r, input int len);
    for (int i = 0; i < len; i++) push(r, 8'($urandom), i == len - 1);
  endtask

  task automatic monitor();
    bit [N-1:0] vin;
    int         o;
    logic [8:0] exp_b;
    vin = bus.req_valid;
    o   = m_owner;
    if (o >= 0) begin
      chk("grant_pass", 32'(grant), 32'(1 << o));
      chk("busy_pass", 32'(busy), 1);
      chk("tx_valid", 32'(bus.tx_valid), 32'(vin[o]));
      chk("tx_data", 32'(bus.tx_data), 32'(bus.req_data[o]));
      chk("tx_last", 32'(bus.tx_last), 32'(bus.req_last[o]));
      chk("req_ready", 32'(bus.req_ready), 32'(bus.tx_ready) << o);
    end else begin
      chk("grant_quiet", 32'(grant), 0);
      chk("tx_valid_quiet", 32'(bus.tx_valid), 0);
      chk("tx_data_quiet", 32'(bus.tx_data), 0);
      chk("tx_last_quiet", 32'(bus.tx_last), 0);
      chk("req_ready_quiet", 32'(bus.req_ready), 0);
      chk("busy_quiet", 32'(busy), 32'(cyc < m_free));
    end
    chk("frames_sent", 32'(frames_sent), 32'(m_frames));

    if (busy) busy_cnt++;
    if (grant == N'(2) && !bus.tx_valid) bubble_cnt++;
    if (grant == N'(1) && bus.req_ready[1]) rr1_hi++;
    if (busy && grant == '0) ifg_run++;
    else if (ifg_run != 0) begin gap_log.push_back(ifg_run); ifg_run = 0; end

    hs_in = vin & bus.req_ready;
    if (o >= 0 && vin[o] && bus.tx_ready) begin
      if (sb_q[o].size() == 0) begin
        chk("sb_underflow", 0, 1);
      end else begin
        exp_b = sb_q[o].pop_front();
        chk("byte", {23'd0, bus.tx_last, bus.tx_data}, {23'd0, exp_b});
        out_log.push_back({bus.tx_last, bus.tx_data});
        if (exp_b[8]) begin
          m_frames++;
          m_owner = -1;
          m_free  = cyc + IFG + 1;
          end_log.push_back(cyc);
        end
      end
    end else if (o < 0 && cyc >= m_free && vin != '0) begin
      m_owner = pick(vin, m_ptr);
      m_ptr   = m_owner;
      grant_log.push_back(m_owner);
      gstart_log.push_back(cyc + 1);
    end
  endtask

  // One clock: sources retire accepted bytes, drive new inputs, then sample at negedge.
  task automatic step();
    @(posedge eth_clk);
    cyc++;
    for (int i = 0; i < N; i++) if (hs_in[i]) void'(drv_q[i].pop_front());
    hs_in = '0;
    #1;
    for (int i = 0; i < N; i++) begin
      bit drop;
      drop = ($urandom_range(99) < drop_pct);
      bus.req_valid[i] = (drv_q[i].size() != 0) && (hold_off[i] == 0) && !drop;
      if (hold_off[i] > 0) hold_off[i]--;
      if (drv_q[i].size() != 0) begin
        bus.req_data[i] = drv_q[i][0][7:0];
        bus.req_last[i] = drv_q[i][0][8];
      end else begin
        bus.req_data[i] = 8'($urandom);
        bus.req_last[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ~bus.tx_ready;
      default: bus.tx_ready = 1'($urandom);
    endcase
    @(negedge eth_clk);
    monitor();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin step(); n++; end
    chk("drain_in_time", 32'(n < max), 1);
  endtask

  initial begin
    int         exp_ord[4];
    int         n;
    logic [8:0] ref0[$];

    sys_rst_n     = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    drop_pct = 0; rdy_mode = 0; cyc = 0;
    busy_cnt = 0; bubble_cnt = 0; rr1_hi = 0;
    model_reset();
    repeat (3) @(posedge eth_clk);
    @(negedge eth_clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    sys_rst_n = 1'b1;

    // Simultaneous requests, two frames each
    clear_logs();
    for (int f = 0; f < 2; f++) begin
      send(0, 2 + $urandom_range(4));
      send(1, 2 + $urandom_range(4));
    end
    drain(2000);
`ifdef ETH_TX_ARB_PRIO_EN
    exp_ord = '{0, 0, 1, 1};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    chk("sim_grants", 32'(grant_log.size()), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("sim_order", 32'(grant_log[i]), 32'(exp_ord[i]));
    chk("sim_gaps", 32'(gap_log.size()), 4);
    foreach (gap_log[i]) chk("sim_ifg_len", 32'(gap_log[i]), IFG);
    for (int i = 0; i + 1 < gstart_log.size() && i < end_log.size(); i++)
      chk("sim_next_start", 32'(gstart_log[i+1] - end_log[i]), IFG + 2);

    // Single frame 55 D5 AA
    clear_logs();
    busy_cnt = 0;
    push(0, 8'h55, 1'b0); push(0, 8'hD5, 1'b0); push(0, 8'hAA, 1'b1);
    drain(500);
    chk("single_len", 32'(out_log.size()), 3);
    if (out_log.size() == 3) begin
      chk("single_b0", 32'(out_log[0]), 32'h055);
      chk("single_b1", 32'(out_log[1]), 32'h0D5);
      chk("single_b2", 32'(out_log[2]), 32'h1AA);
    end
    chk("single_busy", 32'(busy_cnt), 3 + IFG);
    chk("single_frames", 32'(frames_sent), 5);

    // Backpressure: tx_ready toggles, req1 waits behind a 64-byte frame
    clear_logs();
    rr1_hi   = 0;
    rdy_mode = 1;
    send(0, 64);
    ref0 = sb_q[0];
    step();
    send(1, 8);
    drain(2000);
    chk("bp_first", 32'(grant_log.size() != 0 ? grant_log[0] : -1), 0);
    chk("bp_bytes", 32'(out_log.size()), 72);
    for (int i = 0; i < 64 && i < out_log.size(); i++) chk("bp_order", 32'(out_log[i]), 32'(ref0[i]));
    chk("bp_rdy1_quiet", 32'(rr1_hi), 0);
    rdy_mode = 0;

    // Bubble: req1 drops valid for 5 cycles; req0 arrives mid-bubble
    send(1, 10);
    n = 0;
    while (sb_q[1].size() > 6 && n < 200) begin step(); n++; end
    chk("bubble_reach", 32'(n < 200), 1);
    clear_logs();
    bubble_cnt  = 0;
    hold_off[1] = 5;
    send(0, 6);
    drain(1000);
    chk("bubble_cycles", 32'(bubble_cnt), 5);
    chk("bubble_next", 32'(grant_log.size() != 0 ? grant_log[0] : -1), 0);
    if (gstart_log.size() != 0 && end_log.size() != 0)
      chk("bubble_wait_ifg", 32'(gstart_log[0] - end_log[0]), IFG + 2);
    else
      chk("bubble_logs", 0, 1);

    // Reset at byte 10 of a 20-byte frame
    send(0, 20);
    n = 0;
    while (sb_q[0].size() > 10 && n < 200) begin step(); n++; end
    chk("rst_reach", 32'(n < 200), 1);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_grant", 32'(grant), 0);
    chk("rst_mid_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_mid_frames", 32'(frames_sent), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    model_reset();
    bus.req_valid = '0;
    repeat (2) @(posedge eth_clk);
    @(negedge eth_clk);
    sys_rst_n = 1'b1;
    send(1, 5);
    step();
    step();
    chk("rst_regrant", 32'(grant), 32'(N'(2)));
    drain(500);
    chk("rst_frames_after", 32'(frames_sent), 1);

    // Counter wrap
    force dut.frames_sent = 16'hFFFF;
    @(posedge eth_clk);
    #1 release dut.frames_sent;
    m_frames = 16'hFFFF;
    @(negedge eth_clk);
    send(0, 4);
    drain(500);
    chk("wrap", 32'(frames_sent), 0);

    // Randomized soak
    drop_pct = 20;
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      send($urandom_range(N - 1), 1 + $urandom_range(11));
      repeat ($urandom_range(30)) step();
    end
    drain(20000);
    for (int i = 0; i < N; i++) chk("sb_empty", 32'(sb_q[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Shares the single RMII transmit path between `N_REQ` frame sources (e.g. ARP responder, UDP sender, debug echo). Grants whole frames one at a time, passes the granted source's byte stream to the downstream RMII transmit serializer, and enforces a minimum inter-frame gap (IFG) between frames. Sits in the `eth_clk` domain between the frame generators and the `eth_txen`/`eth_tx` serializer.

## Interface
- `N_REQ`, default 2: number of requesters; legal range 2..8.
- `IFG_CYCLES`, default 48: idle `eth_clk` cycles after a frame's last byte is accepted before the next grant. 12 bytes × 4 dibits = 48. Legal range 1..255.
- `eth_clk` in 1: 50 MHz RMII reference clock; the only clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in 8·N_REQ: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last` in N_REQ: marks the final byte of the frame.
- `req_ready` out N_REQ: byte accepted from requester i.
- `tx_valid` out 1: byte valid to the serializer.
- `tx_data` out 8: byte to the serializer.
- `tx_last` out 1: final byte of the frame.
- `tx_ready` in 1: serializer accepts the byte.
- `grant` out N_REQ: one-hot current owner; all-zero when not in PASS.
- `busy` out 1: high in PASS and IFG.
- `frames_sent` out 16: count of completed frames; wraps from 0xFFFF to 0.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, the arbiter registers the winner into `grant` and goes to PASS. With no `req_valid`, it stays in IDLE.
  - PASS: a combinational passthrough from granted index g:
    - `tx_valid` = `req_valid[g]`
    - `tx_data` = `req_data[g]`
    - `tx_last` = `req_last[g]`
    - `req_ready[g]` = `tx_ready`
    - `req_ready` of every other requester is 0.
  - PASS exit: on a handshake (`tx_valid & tx_ready`) with `tx_last`, the block clears `grant`, increments `frames_sent`, loads the IFG counter with `IFG_CYCLES-1` and goes to IFG.
  - IFG: the counter decrements every cycle. At 0 the block goes to IDLE. All `req_ready` and `tx_valid` are 0.
- Arbitration is round-robin.
  - Pointer `rr_last` holds the last granted index; its reset value is `N_REQ-1`, so requester 0 wins first.
  - The search order is `rr_last+1`, `rr_last+2`, … modulo `N_REQ`.
  - The pointer updates on entry to PASS.
- Mid-frame bubbles: if `req_valid[g]` drops before its last byte, `tx_valid` drops and the grant is held. A frame is never preempted.
- Non-granted requesters keep their data pending; their `req_valid` is ignored until they are granted.
- All outputs in IDLE/IFG: `tx_valid`=0, `tx_data`=0, `tx_last`=0, `req_ready`=0.
- Reset values: state=IDLE, `grant`=0, `busy`=0, `frames_sent`=0, `rr_last`=`N_REQ-1`, IFG counter=0, all handshake outputs 0.
- Reset asserted mid-frame or mid-IFG clears everything immediately (asynchronously). The partial frame is abandoned and not counted.

## Timing
- Arbitration latency is 1 cycle: `req_valid` high in IDLE at cycle t gives `grant`/`busy` high and the first byte transferable at t+1.
- `req_valid` rising in the same cycle the FSM enters IDLE is arbitrated in that cycle.
- Passthrough latency is 0 cycles. Throughput is 1 byte/cycle when `tx_ready` is held high.
- Last-byte handshake at cycle t:
  - `grant`=0 and `frames_sent`+1 visible at t+1.
  - IFG occupies cycles t+1 .. t+`IFG_CYCLES`.
  - Earliest next first-byte handshake is t+`IFG_CYCLES`+2.
- When several requests arrive in the same cycle, exactly one is granted, chosen by pointer order.
- `tx_ready` low holds the current byte; a `req_ready` toggle causes no byte loss or duplication.

## Configuration
- `ETH_TX_ARB_PRIO_EN` defined: fixed priority, where the lowest set index of `req_valid` always wins. `rr_last` is not implemented.
- `ETH_TX_ARB_PRIO_EN` undefined (default): round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single frame: req0 sends 0x55,0xD5,0xAA (last) with `tx_ready`=1.
  - Required: `tx_data` sequence 0x55,0xD5,0xAA; `tx_last` on 0xAA; `frames_sent`=1.
  - Required: `busy` high for 3+48 cycles.
- Simultaneous requests: req0 and req1 request together, 2 frames each.
  - Round-robin build: grant order 0,1,0,1.
  - `ETH_TX_ARB_PRIO_EN` build: grant order 0,0,1,1.
  - Both builds: exactly 48 idle cycles between the frames.
- Backpressure: `tx_ready` toggles every other cycle during a 64-byte frame.
  - Required: all 64 bytes arrive in order with none dropped or duplicated.
  - Required: `req_ready[1]` stays 0 throughout.
- Bubble: req1 deasserts `req_valid` for 5 cycles mid-frame.
  - Required: `tx_valid`=0 for those 5 cycles and `grant` stays 0b10.
  - Required: a req0 request arriving during the bubble waits for the IFG.
- Reset mid-frame: `sys_rst_n` pulses low at byte 10 of a 20-byte frame.
  - Required: immediately `grant`=0, `tx_valid`=0, `frames_sent`=0.
  - Required: the next request from req1 alone is granted 1 cycle after reset release plus request.
- Wrap: preload 65535 completed frames (or force the counter), then send one frame.
  - Required: `frames_sent`=0.
